// File: rtl/dmem_dump_reader.sv
// dmem_dump_reader
//
// Debug-side reader for the CPU data memory. A start pulse walks the whole
// byte-addressed memory one aligned 32-bit word at a time through the
// memory's registered read port. Each word is serialized least-significant
// byte first onto a valid/ready byte stream that feeds the debug UART TX.
//
// Ports
//   clk           rising-edge clock
//   i_rst_n       asynchronous active-low reset
//   i_start       start a full dump (sampled only in IDLE)
//   i_dmem_dout   memory read data, valid the cycle after o_dmem_ren
//   i_tx_ready    byte consumer ready
//   o_dmem_raddr  word-aligned byte read address (meaningful while o_dmem_ren)
//   o_dmem_ren    memory read enable
//   o_tx_data     byte being offered
//   o_tx_valid    o_tx_data is valid
//   o_busy        high in every state except IDLE
//   o_done        one-cycle pulse when the dump completes
module dmem_dump_reader #(
   parameter int ADDR_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  i_rst_n,
   input  logic                  i_start,
   input  logic [31:0]           i_dmem_dout,
   input  logic                  i_tx_ready,
   output logic [ADDR_WIDTH-1:0] o_dmem_raddr,
   output logic                  o_dmem_ren,
   output logic [7:0]            o_tx_data,
   output logic                  o_tx_valid,
   output logic                  o_busy,
   output logic                  o_done
);

   // Address of the last aligned word; the walk stops after it rather than
   // wrapping to 0. For ADDR_WIDTH=2 this is 0 (a single-word memory).
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'((2 ** ADDR_WIDTH) - 4);
   localparam logic [ADDR_WIDTH-1:0] WORD_STEP = ADDR_WIDTH'(4);

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_WAIT,
      S_SEND,
      S_DONE
   } state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q,  addr_d;
   logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
   logic [31:0]           word_q,  word_d;
   logic [1:0]            idx_q,   idx_d;

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge value of every other register.
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         raddr_q <= '0;
         word_q  <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         raddr_q <= raddr_d;
         word_q  <= word_d;
         idx_q   <= idx_d;
      end
   end

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   // NOTE: every variable gets its hold value first so no path through the
   // case statement leaves one unassigned (which would infer a latch).
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      raddr_d = raddr_q;
      word_d  = word_q;
      idx_d   = idx_q;

      unique case (state_q)
         S_IDLE: begin
            if (i_start) begin
               addr_d  = '0;
               raddr_d = '0;
               state_d = S_READ;
            end
         end

         // Single-cycle read request; data returns next cycle.
         S_READ: begin
            state_d = S_WAIT;
         end

         // Registered read data is on i_dmem_dout now; capture it.
         S_WAIT: begin
            word_d  = i_dmem_dout;
            idx_d   = '0;
            state_d = S_SEND;
         end

         // Offer byte idx; advance only on a completed handshake so data
         // and valid hold stable under backpressure.
         S_SEND: begin
            if (i_tx_ready) begin
               idx_d = idx_q + 2'd1;
               if (idx_q == 2'd3) begin
                  if (addr_q == LAST_ADDR) begin
                     state_d = S_DONE;
                  end else begin
                     // The read address register only moves when a new READ
                     // is entered, so it holds its last value otherwise.
                     addr_d  = addr_q + WORD_STEP;
                     raddr_d = addr_q + WORD_STEP;
                     state_d = S_READ;
                  end
               end
            end
         end

         S_DONE: begin
            addr_d  = '0;
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Outputs: decoded from the registered state, so the asynchronous
   // reset clears them without waiting for a clock edge.
   // ------------------------------------------------------------------
   assign o_dmem_raddr = raddr_q;
   assign o_dmem_ren   = (state_q == S_READ);
   assign o_tx_valid   = (state_q == S_SEND);
   assign o_tx_data    = (state_q == S_SEND) ? word_q[{idx_q, 3'b000} +: 8] : 8'd0;
   assign o_busy       = (state_q != S_IDLE);
   assign o_done       = (state_q == S_DONE);

endmodule

// File: tb/tb_dmem_dump_reader.sv
// Testbench for dmem_dump_reader: a 32-byte instance (dut_a) and a single-word
// instance (dut_b). Expected reads and bytes are queued by the stimulus and
// popped by negedge monitors whenever the DUT presents a read or a transfer.
module tb_dmem_dump_reader;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;
   int   cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------------------------------------------------------- DUT A
   logic        a_start, a_ready;
   logic [31:0] a_dout;
   logic [4:0]  a_raddr;
   logic        a_ren, a_valid, a_busy, a_done;
   logic [7:0]  a_data;
   logic [31:0] a_mem [8];

   dmem_dump_reader #(.ADDR_WIDTH(5)) dut_a (
      .clk          (clk),
      .i_rst_n      (rst_n),
      .i_start      (a_start),
      .i_dmem_dout  (a_dout),
      .i_tx_ready   (a_ready),
      .o_dmem_raddr (a_raddr),
      .o_dmem_ren   (a_ren),
      .o_tx_data    (a_data),
      .o_tx_valid   (a_valid),
      .o_busy       (a_busy),
      .o_done       (a_done)
   );

   always @(posedge clk) if (a_ren) a_dout <= a_mem[a_raddr[4:2]];

   // ---------------------------------------------------------------- DUT B
   logic        b_start;
   logic [31:0] b_dout;
   logic [1:0]  b_raddr;
   logic        b_ren, b_valid, b_busy, b_done;
   logic [7:0]  b_data;

   dmem_dump_reader #(.ADDR_WIDTH(2)) dut_b (
      .clk          (clk),
      .i_rst_n      (rst_n),
      .i_start      (b_start),
      .i_dmem_dout  (b_dout),
      .i_tx_ready   (1'b1),
      .o_dmem_raddr (b_raddr),
      .o_dmem_ren   (b_ren),
      .o_tx_data    (b_data),
      .o_tx_valid   (b_valid),
      .o_busy       (b_busy),
      .o_done       (b_done)
   );

   always @(posedge clk) if (b_ren) b_dout <= (b_raddr == 2'd0) ? 32'h04030201 : 32'hDEADBEEF;

   // ---------------------------------------------------------- scoreboards
   logic [7:0] a_exp_bytes [$];
   logic [4:0] a_exp_addr  [$];
   logic [7:0] b_exp_bytes [$];
   logic [1:0] b_exp_addr  [$];

   logic       a_prev_stall;
   logic [7:0] a_prev_data;

   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (a_ren) begin
            if (a_exp_addr.size() == 0) check("a_unexpected_read", {27'd0, a_raddr}, 32'hFFFF_FFFF);
            else check("a_raddr", {27'd0, a_raddr}, {27'd0, a_exp_addr.pop_front()});
         end
         if (a_prev_stall) check("a_stall_hold", {23'd0, a_valid, a_data}, {23'd0, 1'b1, a_prev_data});
         if (a_valid && a_ready) begin
            if (a_exp_bytes.size() == 0) check("a_unexpected_byte", {24'd0, a_data}, 32'hFFFF_FFFF);
            else check("a_byte", {24'd0, a_data}, {24'd0, a_exp_bytes.pop_front()});
         end
         a_prev_stall = a_valid && !a_ready;
         a_prev_data  = a_data;
      end else begin
         a_prev_stall = 1'b0;
      end
   end

   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (b_ren) begin
            if (b_exp_addr.size() == 0) check("b_unexpected_read", {30'd0, b_raddr}, 32'hFFFF_FFFF);
            else check("b_raddr", {30'd0, b_raddr}, {30'd0, b_exp_addr.pop_front()});
         end
         if (b_valid) begin
            if (b_exp_bytes.size() == 0) check("b_unexpected_byte", {24'd0, b_data}, 32'hFFFF_FFFF);
            else check("b_byte", {24'd0, b_data}, {24'd0, b_exp_bytes.pop_front()});
         end
      end
   end

   // ------------------------------------------------------------ helpers
   task automatic push_a_full();
      logic [7:0] head [8];
      head = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
      for (int w = 0; w < 8; w++) a_exp_addr.push_back(5'(w * 4));
      for (int i = 0; i < 8; i++) a_exp_bytes.push_back(head[i]);
      for (int i = 0; i < 24; i++) a_exp_bytes.push_back(8'h00);
   endtask

   // mode: 0 plain, 1 backpressure on 0x22, 2 ignored starts, 3 reset in word 3
   task automatic run_a(input string tag, input int mode, input int exp_len);
      int r = -1;
      int d = -1;
      int stall_left = 0;
      bit stalled = 0;
      bit send_pulsed = 0;
      @(posedge clk); #1 a_start = 1'b1;
      for (int n = 0; n < 300; n++) begin
         @(posedge clk); #1;
         a_start = 1'b0;
         if (r < 0 && a_ren) r = cyc;
         if (stall_left > 0) begin
            stall_left--;
            if (stall_left == 0) a_ready = 1'b1;
         end
         if (mode == 1 && !stalled && a_valid && a_data == 8'h22) begin
            a_ready = 1'b0; stall_left = 5; stalled = 1;
         end
         if (mode == 2 && !send_pulsed && a_valid && a_raddr == 5'd8) begin
            a_start = 1'b1; send_pulsed = 1;
         end
         if (mode == 3 && a_valid && a_raddr == 5'd12) begin
            #2 rst_n = 1'b0;
            #1;
            check({tag, "_valid_drop"}, {31'd0, a_valid}, 32'd0);
            check({tag, "_data_zero"}, {24'd0, a_data}, 32'd0);
            check({tag, "_busy_zero"}, {31'd0, a_busy}, 32'd0);
            a_exp_bytes.delete();
            a_exp_addr.delete();
            return;
         end
         if (a_done) begin
            d = cyc;
            if (mode == 2) a_start = 1'b1;
            break;
         end
      end
      if (d < 0) begin
         check({tag, "_done_timeout"}, 32'd0, 32'd1);
         return;
      end
      check({tag, "_length"}, d - r + 1, exp_len);
      @(posedge clk); #1 a_start = 1'b0;
      check({tag, "_done_one_cycle"}, {31'd0, a_done}, 32'd0);
      check({tag, "_idle_busy"}, {31'd0, a_busy}, 32'd0);
      repeat (3) @(posedge clk);
      #1 check({tag, "_still_idle"}, {30'd0, a_busy, a_done}, 32'd0);
      check({tag, "_bytes_drained"}, a_exp_bytes.size(), 32'd0);
      check({tag, "_reads_drained"}, a_exp_addr.size(), 32'd0);
   endtask

   // ------------------------------------------------------------ stimulus
   initial begin
      int r, d;
      for (int i = 0; i < 8; i++) a_mem[i] = 32'h0;
      a_mem[0] = 32'h44332211;
      a_mem[1] = 32'hDDCCBBAA;
      rst_n = 1'b1; a_start = 1'b0; a_ready = 1'b1; b_start = 1'b0;

      // Asynchronous reset between edges, then held for three cycles.
      #2 rst_n = 1'b0;
      #1;
      check("rst_a_outputs", {a_raddr, a_ren, a_data, a_valid, a_busy, a_done}, 32'd0);
      check("rst_b_outputs", {b_raddr, b_ren, b_data, b_valid, b_busy, b_done}, 32'd0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
         check("idle_no_ren", {30'd0, a_ren, a_busy}, 32'd0);
      end

      push_a_full();
      run_a("basic", 0, 49);

      push_a_full();
      run_a("bp", 1, 54);

      push_a_full();
      run_a("ign_start", 2, 49);

      push_a_full();
      run_a("rst_mid", 3, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      push_a_full();
      run_a("after_rst", 0, 49);

      // Single-word memory.
      b_exp_addr.push_back(2'd0);
      b_exp_bytes.push_back(8'h01); b_exp_bytes.push_back(8'h02);
      b_exp_bytes.push_back(8'h03); b_exp_bytes.push_back(8'h04);
      r = -1; d = -1;
      @(posedge clk); #1 b_start = 1'b1;
      for (int n = 0; n < 50; n++) begin
         @(posedge clk); #1;
         b_start = 1'b0;
         if (r < 0 && b_ren) r = cyc;
         if (b_done) begin d = cyc; break; end
      end
      if (d < 0) check("b_done_timeout", 32'd0, 32'd1);
      else check("b_length", d - r + 1, 32'd7);
      repeat (10) @(posedge clk);
      #1;
      check("b_idle_busy", {31'd0, b_busy}, 32'd0);
      check("b_bytes_drained", b_exp_bytes.size(), 32'd0);
      check("b_reads_drained", b_exp_addr.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
